// File: rtl/decode_arbiter_8.sv
// decode_arbiter_8 -- round-robin 8-way arbiter with active-low one-hot (3-to-8 decoder style) grant.
// Optional grant timer enabled by macro DECODE_ARB_TIMEOUT_EN. Rev 1.0
`default_nettype none

module decode_arbiter_8 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt_n,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [7:0] gnt_n_nx;
  logic [2:0] gnt_idx_nx;
  logic       gnt_valid_nx;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       expired;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("decode_arbiter_8: TIMEOUT_CYCLES must be in 2..255");
  end

  // Scan downward so the requester closest above ptr is the last one written.
  always_comb begin
    pick = ptr;
    cand = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) pick = cand;
    end
  end

`ifdef DECODE_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign expired = (hold_cnt == 8'(TIMEOUT_CYCLES));

  // Count equals the number of cycles the current grant has been visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && req[gnt_idx] && expired;
      if (state == IDLE && req != 8'd0)
        hold_cnt <= 8'd1;
      else if (state == GRANT)
        hold_cnt <= hold_cnt + 8'd1;
      else
        hold_cnt <= 8'd0;
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    gnt_n_nx     = gnt_n;
    gnt_idx_nx   = gnt_idx;
    gnt_valid_nx = gnt_valid;
    case (state)
      IDLE: begin
        if (req != 8'd0) begin
          state_nx     = GRANT;
          gnt_n_nx     = ~(8'h01 << pick);
          gnt_idx_nx   = pick;
          gnt_valid_nx = 1'b1;
        end
      end
      GRANT: begin
        // A dropped request wins over an expiring timer: that is a normal release.
        if (!req[gnt_idx] || expired) begin
          state_nx     = RELEASE;
          ptr_nx       = gnt_idx + 3'd1;
          gnt_n_nx     = 8'hFF;
          gnt_idx_nx   = 3'd0;
          gnt_valid_nx = 1'b0;
        end
      end
      RELEASE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx     = IDLE;
        gnt_n_nx     = 8'hFF;
        gnt_idx_nx   = 3'd0;
        gnt_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt_n     <= 8'hFF;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt_n     <= gnt_n_nx;
      gnt_idx   <= gnt_idx_nx;
      gnt_valid <= gnt_valid_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_arbiter_8.sv
// tb_decode_arbiter_8 -- scoreboard bench for decode_arbiter_8 (TIMEOUT_CYCLES = 4).
`default_nettype none

module tb_decode_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt_n;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  decode_arbiter_8 #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic [2:0] idx;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   exp_timeouts = 0;
  int   total = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic expect_grant(input logic [2:0] idx, input int len);
    exp_t e;
    e.idx = idx;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Returns at the first falling clock edge on which a new grant is visible.
  task automatic wait_grant(input int budget);
    int n = 0;
    while (gnt_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_valid && n < budget);
    if (!gnt_valid) check(1'b0, "wait_grant_timeout", n, budget);
  endtask

  task automatic check_reset_outputs(input string name);
    check({timeout, gnt_valid, gnt_idx, gnt_n} == {1'b0, 1'b0, 3'd0, 8'hFF}, name,
          {timeout, gnt_valid, gnt_idx, gnt_n}, {1'b0, 1'b0, 3'd0, 8'hFF});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    check_reset_outputs("reset_async");
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
  endtask

  // Monitor: invariants every cycle, grant start/length against the queue, timeout pulses.
  initial begin
    bit         prev_valid = 1'b0;
    bit         prev_to = 1'b0;
    int         cur_len = 0;
    int         cur_exp_len = -1;
    logic [7:0] exp_n;
    exp_t       e;
    forever begin
      @(negedge clk);
      check($countones(~gnt_n) <= 1, "gnt_n_onehot", gnt_n, 8'hFF);
      if (gnt_valid) begin
        exp_n = ~(8'h01 << gnt_idx);
        check(gnt_n == exp_n, "gnt_n_vs_idx", gnt_n, exp_n);
      end else begin
        check(gnt_n == 8'hFF && gnt_idx == 3'd0, "no_grant_outputs", {gnt_idx, gnt_n}, {3'd0, 8'hFF});
      end
      if (gnt_valid && !prev_valid) begin
        cur_len = 1;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_grant", gnt_idx, 0);
          cur_exp_len = -1;
        end else begin
          e = exp_q.pop_front();
          exp_n = ~(8'h01 << e.idx);
          check(gnt_idx == e.idx, "grant_idx", gnt_idx, e.idx);
          check(gnt_n == exp_n, "grant_gnt_n", gnt_n, exp_n);
          cur_exp_len = e.len;
        end
      end else if (gnt_valid) begin
        cur_len++;
      end
      if (!gnt_valid && prev_valid)
        check(cur_len == cur_exp_len, "grant_len", cur_len, cur_exp_len);
      if (timeout) begin
        check(exp_timeouts > 0 && !prev_to && !gnt_valid, "timeout_pulse", {prev_to, gnt_valid}, exp_timeouts);
        if (exp_timeouts > 0) exp_timeouts--;
      end
      prev_valid = gnt_valid;
      prev_to    = timeout;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d grants still pending", exp_q.size());
    $fatal(1);
  end

  initial begin
    logic [2:0] b;
    rst_n = 1'b0;
    req   = 8'h00;
    do_reset();

    // Single requester right after reset release.
    expect_grant(3'd2, 1);
    req = 8'h04;
    wait_grant(20);
    check(gnt_n == 8'hFB, "req04_gnt_n", gnt_n, 8'hFB);
    req = 8'h00;

    // Full round robin from ptr = 0, including wrap back to 0.
    repeat (3) @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) expect_grant(3'(i), 1);
    expect_grant(3'd0, 1);
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_grant(20);
      b = gnt_idx;
      req[b] = 1'b0;
      @(negedge clk);
      if (i == 8) req = 8'h00;
      else req[b] = 1'b1;
    end

    // Grant held at 7 with 0 also requesting: wrap to 0 next.
    expect_grant(3'd7, 3);
    expect_grant(3'd0, 1);
    req = 8'h80;
    wait_grant(20);
    req = 8'h81;
    repeat (2) @(negedge clk);
    req = 8'h01;
    wait_grant(20);
    req = 8'h00;

    // Asynchronous reset in the middle of a grant.
    expect_grant(3'd5, 1);
    req = 8'h20;
    wait_grant(20);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_grant");
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    expect_grant(3'd5, 1);
    req = 8'h20;
    wait_grant(20);
    req = 8'h00;

    // Two requesters held: timer revokes idx 0 when enabled, else it holds.
`ifdef DECODE_ARB_TIMEOUT_EN
    expect_grant(3'd0, 4);
    expect_grant(3'd1, 1);
    exp_timeouts = 1;
    req = 8'h03;
    wait_grant(20);
    wait_grant(20);
    req = 8'h00;
`else
    expect_grant(3'd0, 21);
    req = 8'h03;
    wait_grant(20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check(gnt_valid && gnt_idx == 3'd0 && !timeout, "hold_no_timer", {timeout, gnt_valid, gnt_idx}, 5'b01000);
    end
    req = 8'h00;
`endif

    // Request drops exactly when the count would expire: normal release.
    expect_grant(3'd4, 4);
    req = 8'h10;
    wait_grant(20);
    repeat (3) @(negedge clk);
    req = 8'h00;

    repeat (6) @(negedge clk);
    check(exp_q.size() == 0, "pending_grants", exp_q.size(), 0);
    check(exp_timeouts == 0, "pending_timeouts", exp_timeouts, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
